// File: rtl/crc_frame_ctrl_if.sv
// Word-stream and result handshake bundle for crc_frame_ctrl.
// master = producer/consumer side, slave = the frame controller.
interface crc_frame_ctrl_if #(
    parameter int DATA_W  = 8,
    parameter int CRC_LEN = 32
);
    logic [DATA_W-1:0]  s_data;
    logic               s_valid;
    logic               s_last;
    logic               s_ready;
    logic [CRC_LEN-1:0] crc_value;
    logic               crc_valid;
    logic               crc_ready;

    modport master (
        output s_data,
        output s_valid,
        output s_last,
        input  s_ready,
        input  crc_value,
        input  crc_valid,
        output crc_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        input  s_last,
        output s_ready,
        output crc_value,
        output crc_valid,
        input  crc_ready
    );
endinterface

// File: rtl/crc_frame_ctrl.sv
// Frame sequencer for a one-bit-per-cycle CRC core: clears it at frame start, feeds words
// MSB-first, appends CRC_LEN zero bits of augmentation, then hands out the captured remainder.
module crc_frame_ctrl #(
    parameter int CRC_LEN = 32,
    parameter int DATA_W  = 8
) (
    input  logic               clk_in,
    input  logic               reset,
    crc_frame_ctrl_if.slave    bus,
    input  logic               abort,
    output logic               crc_reset_out,
    output logic               crc_enable_out,
    output logic               crc_data_out,
    input  logic [CRC_LEN-1:0] crc_in,
    output logic               busy
);
    localparam int BIT_W = $clog2(DATA_W);
    localparam int PAD_W = $clog2(CRC_LEN + 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [PAD_W-1:0] PAD_LAST = PAD_W'(CRC_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SHIFT,
        PAD,
        CAPTURE,
        DONE
    } state_e;

    state_e             state_q;
    logic [DATA_W-1:0]  shreg_q;
    logic               last_q;
    logic               frame_open_q;
    logic [BIT_W-1:0]   bit_cnt_q;
    logic [PAD_W-1:0]   pad_cnt_q;
    logic [CRC_LEN-1:0] crc_value_q;
    logic               crc_valid_q;
    logic               accept;

    // Ready is withheld during reset/abort so a word offered then is never taken.
    assign bus.s_ready   = (state_q == IDLE) & ~reset & ~abort;
    assign accept        = bus.s_valid & bus.s_ready;
    assign bus.crc_value = crc_value_q;
    assign bus.crc_valid = crc_valid_q;
    assign busy          = (state_q != IDLE) | frame_open_q;

    // Core pins decode straight from the state register so the core acts on the same edge.
    assign crc_reset_out  = reset | (state_q == CLEAR);
    assign crc_enable_out = (state_q == SHIFT) | (state_q == PAD);
    assign crc_data_out   = (state_q == SHIFT) & shreg_q[DATA_W-1];

    always_ff @(posedge clk_in) begin
        if (reset || abort) begin
            state_q      <= IDLE;
            frame_open_q <= 1'b0;
            crc_valid_q  <= 1'b0;
            last_q       <= 1'b0;
            bit_cnt_q    <= '0;
            pad_cnt_q    <= '0;
            if (reset) begin
                crc_value_q <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        shreg_q   <= bus.s_data;
                        last_q    <= bus.s_last;
                        bit_cnt_q <= '0;
                        if (!frame_open_q) begin
                            state_q      <= CLEAR;
                            frame_open_q <= 1'b1;
                        end else begin
                            state_q <= SHIFT;
                        end
                    end
                end
                CLEAR: begin
                    state_q <= SHIFT;
                end
                SHIFT: begin
                    shreg_q <= {shreg_q[DATA_W-2:0], 1'b0};
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_q <= '0;
                        if (last_q) begin
                            state_q      <= PAD;
                            frame_open_q <= 1'b0;
                            pad_cnt_q    <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                    end
                end
                PAD: begin
                    if (pad_cnt_q == PAD_LAST) begin
                        pad_cnt_q <= '0;
                        state_q   <= CAPTURE;
                    end else begin
                        pad_cnt_q <= pad_cnt_q + PAD_W'(1);
                    end
                end
                CAPTURE: begin
                    // Last augmentation bit entered the core on the previous edge.
                    crc_value_q <= crc_in;
                    crc_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (bus.crc_ready) begin
                        crc_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_crc_frame_ctrl.sv
// Bench for crc_frame_ctrl: drives it with a serial CRC-8 (poly 0x07) core model and checks
// every cycle against a timeline model plus polynomial-division reference for the remainder.
module tb_crc_frame_ctrl;
    localparam int CRC_LEN = 8;
    localparam int DATA_W  = 8;
    localparam logic [CRC_LEN:0] POLY = 9'h107;

    logic               clk_in = 1'b0;
    logic               reset;
    logic               abort;
    logic               crc_reset_out;
    logic               crc_enable_out;
    logic               crc_data_out;
    logic [CRC_LEN-1:0] crc_in;
    logic               busy;

    crc_frame_ctrl_if #(.DATA_W(DATA_W), .CRC_LEN(CRC_LEN)) bus ();

    crc_frame_ctrl #(.CRC_LEN(CRC_LEN), .DATA_W(DATA_W)) dut (
        .clk_in         (clk_in),
        .reset          (reset),
        .bus            (bus),
        .abort          (abort),
        .crc_reset_out  (crc_reset_out),
        .crc_enable_out (crc_enable_out),
        .crc_data_out   (crc_data_out),
        .crc_in         (crc_in),
        .busy           (busy)
    );

    initial forever #5 clk_in = ~clk_in;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Serial CRC core: remainder register shifting in one message bit per enabled edge.
    logic               core_rst_s = 1'b1;
    logic               core_en_s  = 1'b0;
    logic               core_d_s   = 1'b0;
    logic [CRC_LEN-1:0] core_q;
    assign crc_in = core_q;

    always @(negedge clk_in) begin
        core_rst_s = crc_reset_out;
        core_en_s  = crc_enable_out;
        core_d_s   = crc_data_out;
    end

    always @(posedge clk_in) begin
        if (core_rst_s) core_q <= '0;
        else if (core_en_s)
            core_q <= {core_q[CRC_LEN-2:0], core_d_s} ^ (core_q[CRC_LEN-1] ? POLY[CRC_LEN-1:0] : '0);
    end

    // Reference remainder: (message * x^CRC_LEN) mod P by plain long division.
    function automatic logic [CRC_LEN-1:0] ref_crc(input logic [DATA_W-1:0] w[$]);
        logic [127:0] m;
        m = '0;
        foreach (w[i]) m = (m << DATA_W) | 128'(w[i]);
        m = m << CRC_LEN;
        for (int i = 127; i >= CRC_LEN; i--)
            if (m[i]) m = m ^ (128'(POLY) << (i - CRC_LEN));
        return m[CRC_LEN-1:0];
    endfunction

    // Timeline model: each accepted word occupies a fixed number of cycles after its handshake.
    logic [DATA_W-1:0]  m_frame[$];
    logic [DATA_W-1:0]  m_word    = '0;
    logic [CRC_LEN-1:0] m_value   = '0;
    bit                 m_active  = 0;
    bit                 m_valid   = 0;
    bit                 m_open    = 0;
    bit                 m_last    = 0;
    bit                 m_val_zero = 0;
    bit                 m_gap     = 0;
    int                 m_pre     = 0;
    int                 m_pos     = 0;
    int                 m_total   = 0;
    int                 m_en_cnt  = 0;
    int                 m_t0      = 0;
    int                 cyc       = 0;
    int                 en_tot    = 0;
    int                 clr_cnt   = 0;
    logic [15:0]        ser       = '0;

    always @(posedge clk_in) begin
        int n;
        cyc++;
        if (reset || abort) begin
            m_active = 0;
            m_valid  = 0;
            m_open   = 0;
            m_frame.delete();
            if (reset) m_val_zero = 1;
        end else if (m_valid) begin
            if (bus.crc_ready) m_valid = 0;
        end else if (m_active) begin
            m_pos++;
            if (m_pos == m_total) begin
                m_active = 0;
                if (m_last) begin
                    n = m_frame.size();
                    m_valid    = 1;
                    m_value    = ref_crc(m_frame);
                    m_val_zero = 0;
                    check("enable_cycles", 64'(m_en_cnt), 64'(n * DATA_W + CRC_LEN));
                    if (!m_gap)
                        check("frame_latency", 64'(cyc - m_t0),
                              64'(1 + n * DATA_W + (n - 1) + CRC_LEN + 1));
                    m_frame.delete();
                end
            end
        end else if (bus.s_valid) begin
            if (!m_open) begin
                m_pre    = 1;
                m_en_cnt = 0;
                m_t0     = cyc;
                m_gap    = 0;
            end else begin
                m_pre = 0;
            end
            m_frame.push_back(bus.s_data);
            m_word   = bus.s_data;
            m_last   = bus.s_last;
            m_open   = !bus.s_last;
            m_pos    = 0;
            m_active = 1;
            m_total  = m_pre + DATA_W + (m_last ? CRC_LEN + 1 : 0);
        end else if (m_open) begin
            m_gap = 1;
        end
    end

    always @(negedge clk_in) begin
        logic e_en, e_d, e_rst, e_rdy, e_busy;
        e_en   = m_active && m_pos >= m_pre && m_pos < m_pre + DATA_W + (m_last ? CRC_LEN : 0);
        e_d    = (m_active && m_pos >= m_pre && m_pos < m_pre + DATA_W)
                 ? m_word[DATA_W-1-(m_pos-m_pre)] : 1'b0;
        e_rst  = reset || (m_active && m_pos < m_pre);
        e_rdy  = !m_active && !m_valid && !reset && !abort;
        e_busy = m_active || m_valid || m_open;
        if (crc_enable_out === 1'b1) begin
            m_en_cnt++;
            en_tot++;
            ser = {ser[14:0], crc_data_out};
        end
        if (crc_reset_out === 1'b1 && !reset) clr_cnt++;
        check("crc_enable_out", 64'(crc_enable_out), 64'(e_en));
        check("crc_data_out", 64'(crc_data_out), 64'(e_d));
        check("crc_reset_out", 64'(crc_reset_out), 64'(e_rst));
        check("s_ready", 64'(bus.s_ready), 64'(e_rdy));
        check("crc_valid", 64'(bus.crc_valid), 64'(m_valid));
        check("busy", 64'(busy), 64'(e_busy));
        if (m_valid) check("crc_value", 64'(bus.crc_value), 64'(m_value));
        else if (m_val_zero) check("crc_value_reset", 64'(bus.crc_value), 64'(0));
    end

    // Result consumer: random or forced crc_ready.
    bit rdy_rand  = 0;
    bit rdy_force = 1;
    initial begin
        bus.crc_ready = 1'b0;
        forever begin
            @(posedge clk_in);
            #2;
            bus.crc_ready = rdy_rand ? ($urandom_range(0, 2) == 0) : rdy_force;
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #2;
    endtask

    task automatic send_word(input logic [DATA_W-1:0] d, input logic last);
        bit done;
        done = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = last;
        for (int b = 0; b < 400 && !done; b++) begin
            @(negedge clk_in);
            if (bus.s_ready === 1'b1) begin
                tick();
                done = 1;
            end
        end
        if (!done) begin
            fail_now("s_ready_wait");
            tick();
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] w[$], input int gap_max);
        foreach (w[i]) begin
            send_word(w[i], i == w.size() - 1);
            if (i != w.size() - 1) repeat ($urandom_range(0, gap_max)) tick();
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 0;
        for (int b = 0; b < 400 && !ok; b++) begin
            @(negedge clk_in);
            if (bus.crc_valid === 1'b1) ok = 1;
        end
        if (!ok) fail_now("crc_valid_wait");
    endtask

    task automatic expect_result(input string name, input logic [CRC_LEN-1:0] lit);
        bit ok;
        wait_valid(ok);
        if (ok) begin
            check(name, 64'(bus.crc_value), 64'(lit));
            for (int b = 0; b < 400 && bus.crc_valid === 1'b1; b++) @(negedge clk_in);
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int b = 0; b < 600 && !ok; b++) begin
            @(negedge clk_in);
            if (busy === 1'b0 && bus.crc_valid === 1'b0) ok = 1;
        end
        if (!ok) fail_now("idle_wait");
        tick();
    endtask

    initial begin
        logic [DATA_W-1:0] q[$];
        int en0;
        bit ok;

        reset = 1'b1;
        abort = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;

        // Pin the reference itself against hand-computed CRC-8/0x07 remainders.
        q = {8'h01};       check("ref_0x01", 64'(ref_crc(q)), 64'h07);
        q = {8'h02};       check("ref_0x02", 64'(ref_crc(q)), 64'h0E);
        q = {8'h00, 8'h01}; check("ref_0x00_0x01", 64'(ref_crc(q)), 64'h07);

        repeat (3) tick();
        check("reset_s_ready", 64'(bus.s_ready), 64'(0));
        check("reset_crc_reset_out", 64'(crc_reset_out), 64'(1));
        reset = 1'b0;
        @(negedge clk_in);
        check("post_reset_s_ready", 64'(bus.s_ready), 64'(1));
        check("post_reset_busy", 64'(busy), 64'(0));
        check("post_reset_crc_value", 64'(bus.crc_value), 64'(0));
        tick();

        // Single word 0x01: 16 enable cycles carrying 00000001 then eight zeros.
        en0 = en_tot;
        q = {8'h01};
        send_frame(q, 0);
        expect_result("single_0x01", 8'h07);
        check("single_enables", 64'(en_tot - en0), 64'(16));
        check("single_serial_bits", 64'(ser), 64'h0100);
        wait_idle();

        // Two words with a 5-cycle gap: one CLEAR, enable quiet during the gap.
        clr_cnt = 0;
        send_word(8'h00, 1'b0);
        for (int b = 0; b < 40 && busy === 1'b1 && bus.s_ready !== 1'b1; b++) @(negedge clk_in);
        tick();
        repeat (5) begin
            @(negedge clk_in);
            check("gap_enable", 64'(crc_enable_out), 64'(0));
            check("gap_busy", 64'(busy), 64'(1));
            tick();
        end
        send_word(8'h01, 1'b1);
        expect_result("gap_0x00_0x01", 8'h07);
        check("gap_clear_once", 64'(clr_cnt), 64'(1));
        wait_idle();

        // Back-to-back frames with crc_ready high.
        fork
            begin
                q = {8'h01}; send_frame(q, 0);
                q = {8'h02}; send_frame(q, 0);
            end
            begin
                expect_result("b2b_first", 8'h07);
                expect_result("b2b_second", 8'h0E);
            end
        join
        wait_idle();

        // Consumer stalls 10 cycles in DONE while the next word is already offered.
        rdy_force = 0;
        fork
            begin
                q = {8'h01}; send_frame(q, 0);
                q = {8'h55}; send_frame(q, 0);
            end
            begin
                wait_valid(ok);
                repeat (10) begin
                    check("stall_valid", 64'(bus.crc_valid), 64'(1));
                    check("stall_value", 64'(bus.crc_value), 64'h07);
                    check("stall_s_ready", 64'(bus.s_ready), 64'(0));
                    @(negedge clk_in);
                end
                rdy_force = 1;
            end
        join
        wait_idle();

        // Abort mid-SHIFT, then mid-PAD, then together with an offered word in IDLE.
        send_word(8'h3C, 1'b1);
        repeat (4) tick();
        abort = 1'b1; tick(); abort = 1'b0;
        @(negedge clk_in);
        check("abort_shift_busy", 64'(busy), 64'(0));
        tick();
        send_word(8'hC3, 1'b1);
        repeat (13) tick();
        abort = 1'b1; tick(); abort = 1'b0;
        @(negedge clk_in);
        check("abort_pad_busy", 64'(busy), 64'(0));
        tick();
        fork
            send_word(8'h01, 1'b1);
            begin abort = 1'b1; tick(); abort = 1'b0; end
        join
        expect_result("after_abort_0x01", 8'h07);
        wait_idle();

        // Reset for two cycles mid-frame.
        send_word(8'hA5, 1'b0);
        repeat (3) tick();
        reset = 1'b1;
        @(negedge clk_in); check("mid_reset_crc_reset_1", 64'(crc_reset_out), 64'(1));
        tick();
        @(negedge clk_in); check("mid_reset_crc_reset_2", 64'(crc_reset_out), 64'(1));
        check("mid_reset_busy", 64'(busy), 64'(0));
        check("mid_reset_crc_value", 64'(bus.crc_value), 64'(0));
        tick();
        reset = 1'b0;
        tick();
        q = {8'h02};
        send_frame(q, 0);
        expect_result("after_reset_0x02", 8'h0E);
        wait_idle();

        // Randomised frames, gaps, consumer stalls and occasional aborts.
        rdy_rand = 1;
        for (int f = 0; f < 40; f++) begin
            q.delete();
            repeat ($urandom_range(1, 4)) q.push_back(DATA_W'($urandom));
            send_frame(q, ($urandom_range(0, 2) == 0) ? 3 : 0);
            if ($urandom_range(0, 5) == 0) begin
                repeat ($urandom_range(0, 30)) tick();
                abort = 1'b1; tick(); abort = 1'b0;
            end
            wait_idle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
